// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage core pipeline control:
// sequencer state encoding, register-index constants.
package pipeline_pkg;

  localparam int REG_W_DEFAULT = 5;
  localparam int REG_X0        = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REFILL   = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard sequencer (master) and the
// datapath (slave).
// Enable semantics: a register loads on a clock edge only while its enable is
// high; a flush makes it load a bubble.
// The datapath must hold ID/EX fields steady while StageEn is low, so a
// suppressed event is presented again.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] IDRs1;
  logic [REG_W-1:0] IDRs2;
  logic             IDUsesRs2;
  logic [REG_W-1:0] EXRd;
  logic             EXMemRead;
  logic             BranchTaken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             StageEn;

  modport master (
    input  IDRs1, IDRs2, IDUsesRs2, EXRd, EXMemRead, BranchTaken, MemBusy,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StageEn
  );

  modport slave (
    output IDRs1, IDRs2, IDUsesRs2, EXRd, EXMemRead, BranchTaken, MemBusy,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StageEn
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. x0 is never a real dependency.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] IDRs1,
  input  logic [REG_W-1:0] IDRs2,
  input  logic             IDUsesRs2,
  input  logic [REG_W-1:0] EXRd,
  input  logic             EXMemRead,
  output logic             LoadUse
);
  logic rdLive;

  assign rdLive  = EXMemRead && (EXRd != REG_W'(REG_X0));
  assign LoadUse = rdLive && ((EXRd == IDRs1) || (IDUsesRs2 && (EXRd == IDRs2)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch redirect with IF refill window,
// and whole-pipe freeze on a busy data memory. Also counts lost issue slots.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REFILL_CYCLES = 2,
  parameter int CNT_W         = 32,
  parameter int REG_W         = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.master    bus,
  output logic [1:0]       CtrlState,
  output logic [CNT_W-1:0] StallCycles
);
  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(REFILL_CYCLES - 1);

  ctrl_state_e     State, NextState, RetState, NextRetState, EffState;
  logic [RC_W-1:0] RefillCnt, NextRefillCnt;
  logic            loadUse;
  logic            pcWrite, ifidWrite, ifidFlush, idexFlush, stageEn;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .IDRs1     (bus.IDRs1),
    .IDRs2     (bus.IDRs2),
    .IDUsesRs2 (bus.IDUsesRs2),
    .EXRd      (bus.EXRd),
    .EXMemRead (bus.EXMemRead),
    .LoadUse   (loadUse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      State       <= RUN;
      RetState    <= RUN;
      RefillCnt   <= '0;
      StallCycles <= '0;
    end else begin
      State     <= NextState;
      RetState  <= NextRetState;
      RefillCnt <= NextRefillCnt;
      if ((!pcWrite || ifidFlush) && (StallCycles != {CNT_W{1'b1}}))
        StallCycles <= StallCycles + CNT_W'(1);
    end
  end

  // Releasing MEM_WAIT behaves exactly as the interrupted state would, so no bubble.
  always_comb begin
    NextState     = State;
    NextRetState  = RetState;
    NextRefillCnt = RefillCnt;
    pcWrite       = 1'b0;
    ifidWrite     = 1'b0;
    ifidFlush     = 1'b0;
    idexFlush     = 1'b0;
    stageEn       = 1'b0;
    EffState      = (State == MEM_WAIT) ? RetState : State;
    if (rst) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (!(State inside {RUN, REFILL, MEM_WAIT})) begin
      NextState = RUN;
    end else if (bus.MemBusy) begin
      NextState = MEM_WAIT;
      if (State != MEM_WAIT) NextRetState = State;
    end else begin
      NextState = RUN;
      stageEn   = 1'b1;
      if (bus.BranchTaken) begin
        pcWrite       = 1'b1;
        ifidWrite     = 1'b1;
        ifidFlush     = 1'b1;
        idexFlush     = 1'b1;
        NextRefillCnt = RC_INIT;
        if (REFILL_CYCLES > 1) NextState = REFILL;
      end else if (EffState == REFILL) begin
        // ID holds a bubble during refill, so no load-use check here.
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        ifidFlush = 1'b1;
        if (RefillCnt > RC_W'(1)) begin
          NextState     = REFILL;
          NextRefillCnt = RefillCnt - RC_W'(1);
        end else begin
          NextRefillCnt = '0;
        end
      end else if (loadUse) begin
        idexFlush = 1'b1;
      end else begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
      end
    end
  end

  assign bus.PCWrite   = pcWrite;
  assign bus.IFIDWrite = ifidWrite;
  assign bus.IFIDFlush = ifidFlush;
  assign bus.IDEXFlush = idexFlush;
  assign bus.StageEn   = stageEn;
  assign CtrlState     = State;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a slot-level model of the pipeline sequencing rules.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int RC = 2;
  localparam int RW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RW-1:0] idRs1, idRs2, exRd;
  logic          idUsesRs2, exMemRead, branchTaken, memBusy;
  logic [1:0]    ctrlState, ctrlStateSat;
  logic [31:0]   stallCycles;
  logic [3:0]    stallSat;

  hazard_ctrl_if #(.REG_W(RW)) bus ();
  hazard_ctrl_if #(.REG_W(RW)) busSat ();

  assign bus.IDRs1       = idRs1;
  assign bus.IDRs2       = idRs2;
  assign bus.IDUsesRs2   = idUsesRs2;
  assign bus.EXRd        = exRd;
  assign bus.EXMemRead   = exMemRead;
  assign bus.BranchTaken = branchTaken;
  assign bus.MemBusy     = memBusy;
  assign busSat.IDRs1       = idRs1;
  assign busSat.IDRs2       = idRs2;
  assign busSat.IDUsesRs2   = idUsesRs2;
  assign busSat.EXRd        = exRd;
  assign busSat.EXMemRead   = exMemRead;
  assign busSat.BranchTaken = branchTaken;
  assign busSat.MemBusy     = memBusy;

  hazard_ctrl #(.REFILL_CYCLES(RC), .CNT_W(32), .REG_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .CtrlState   (ctrlState),
    .StallCycles (stallCycles)
  );

  hazard_ctrl #(.REFILL_CYCLES(RC), .CNT_W(4), .REG_W(RW)) dutSat (
    .clk         (clk),
    .rst         (rst),
    .bus         (busSat.master),
    .CtrlState   (ctrlStateSat),
    .StallCycles (stallSat)
  );

  int nTests = 0;
  int nFail  = 0;
  logic [4:0] exp_q[$];

  // Reference model: remaining refill slots, whether last slot was frozen, lost slots.
  int          mRefillLeft;
  bit          mFrozen;
  logic [31:0] mStalls;
  int          mStallsSat;
  logic [4:0]  mOut;

  function automatic bit loadUseRef();
    return exMemRead && (exRd != 0) &&
           ((exRd == idRs1) || (idUsesRs2 && (exRd == idRs2)));
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StageEn}
  function automatic logic [4:0] expOut();
    if (rst)              return 5'b00110;
    if (memBusy)          return 5'b00000;
    if (branchTaken)      return 5'b11111;
    if (mRefillLeft > 0)  return 5'b11101;
    if (loadUseRef())     return 5'b00011;
    return 5'b11001;
  endfunction

  function automatic logic [1:0] expState();
    if (mFrozen)         return 2'd2;
    if (mRefillLeft > 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [4:0] actOut();
    return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXFlush, bus.StageEn};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mRefillLeft = 0;
      mFrozen     = 1'b0;
      mStalls     = '0;
      mStallsSat  = 0;
    end else begin
      mOut = expOut();
      if (!mOut[4] || mOut[2]) begin
        mStalls = mStalls + 1;
        if (mStallsSat < 15) mStallsSat = mStallsSat + 1;
      end
      if (memBusy) begin
        mFrozen = 1'b1;
      end else begin
        mFrozen = 1'b0;
        if (branchTaken)          mRefillLeft = RC - 1;
        else if (mRefillLeft > 0) mRefillLeft = mRefillLeft - 1;
      end
    end
  end

  // driver tasks
  task automatic setIdle();
    idRs1 = 5'd1; idRs2 = 5'd2; idUsesRs2 = 1'b1; exRd = 5'd3;
    exMemRead = 1'b0; branchTaken = 1'b0; memBusy = 1'b0;
  endtask

  task automatic setLoadUse();
    exMemRead = 1'b1; exRd = 5'd5; idRs1 = 5'd5;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    setIdle();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      nTests++;
      if (actOut() !== 5'b00110) begin
        nFail++; $display("FAIL reset_outputs: got %b expected 00110", actOut());
      end
      nTests++;
      if (stallCycles !== 32'd0) begin
        nFail++; $display("FAIL reset_stalls: got %0d expected 0", stallCycles);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nTests++;
    if (ctrlState !== 2'd0 || bus.PCWrite !== 1'b1) begin
      nFail++; $display("FAIL reset_release: state %0d pcwrite %b expected 0 1", ctrlState, bus.PCWrite);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    @(negedge clk);
    setIdle(); setLoadUse();
    #1;
    s0 = stallCycles;
    nTests++;
    if (actOut() !== 5'b00011) begin
      nFail++; $display("FAIL load_use_outputs: got %b expected 00011", actOut());
    end
    @(negedge clk);
    setIdle();
    #1;
    nTests++;
    if (stallCycles !== s0 + 32'd1 || actOut() !== 5'b11001) begin
      nFail++; $display("FAIL load_use_one_bubble: stalls %0d out %b expected %0d 11001", stallCycles, actOut(), s0 + 32'd1);
    end
    @(negedge clk);
    exMemRead = 1'b1; exRd = 5'd0; idRs1 = 5'd0;
    #1;
    nTests++;
    if (actOut() !== 5'b11001) begin
      nFail++; $display("FAIL load_use_x0: got %b expected 11001", actOut());
    end
    @(negedge clk);
    exRd = 5'd5; idRs1 = 5'd3; idRs2 = 5'd5; idUsesRs2 = 1'b0;
    #1;
    nTests++;
    if (actOut() !== 5'b11001) begin
      nFail++; $display("FAIL load_use_rs2_unused: got %b expected 11001", actOut());
    end
    @(negedge clk);
    idUsesRs2 = 1'b1;
    #1;
    nTests++;
    if (actOut() !== 5'b00011) begin
      nFail++; $display("FAIL load_use_rs2: got %b expected 00011", actOut());
    end
  endtask

  task automatic test_branch();
    logic [31:0] s0;
    @(negedge clk);
    setIdle();
    branchTaken = 1'b1;
    #1;
    s0 = stallCycles;
    nTests++;
    if (actOut() !== 5'b11111) begin
      nFail++; $display("FAIL branch_cycle0: got %b expected 11111", actOut());
    end
    @(negedge clk);
    branchTaken = 1'b0;
    #1;
    nTests++;
    if (ctrlState !== 2'd1 || actOut() !== 5'b11101) begin
      nFail++; $display("FAIL branch_cycle1: state %0d out %b expected 1 11101", ctrlState, actOut());
    end
    @(negedge clk);
    #1;
    nTests++;
    if (ctrlState !== 2'd0 || actOut() !== 5'b11001 || stallCycles !== s0 + 32'd2) begin
      nFail++; $display("FAIL branch_cycle2: state %0d out %b stalls %0d expected 0 11001 %0d", ctrlState, actOut(), stallCycles, s0 + 32'd2);
    end
  endtask

  task automatic test_freeze_refill();
    @(negedge clk);
    setIdle();
    branchTaken = 1'b1;
    @(negedge clk);
    branchTaken = 1'b0;
    memBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      nTests++;
      if (actOut() !== 5'b00000 || ctrlState !== ((i == 0) ? 2'd1 : 2'd2)) begin
        nFail++; $display("FAIL freeze_cycle%0d: out %b state %0d", i, actOut(), ctrlState);
      end
    end
    @(negedge clk);
    memBusy = 1'b0;
    #1;
    nTests++;
    if (actOut() !== 5'b11101 || ctrlState !== 2'd2) begin
      nFail++; $display("FAIL freeze_release: out %b state %0d expected 11101 2", actOut(), ctrlState);
    end
    @(negedge clk);
    #1;
    nTests++;
    if (actOut() !== 5'b11001 || ctrlState !== 2'd0) begin
      nFail++; $display("FAIL freeze_back_to_run: out %b state %0d expected 11001 0", actOut(), ctrlState);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    setIdle(); setLoadUse();
    branchTaken = 1'b1; memBusy = 1'b1;
    #1;
    nTests++;
    if (actOut() !== 5'b00000) begin
      nFail++; $display("FAIL simul_freeze: got %b expected 00000", actOut());
    end
    @(negedge clk);
    memBusy = 1'b0;
    #1;
    nTests++;
    if (actOut() !== 5'b11111 || ctrlState !== 2'd2) begin
      nFail++; $display("FAIL simul_release_redirect: out %b state %0d expected 11111 2", actOut(), ctrlState);
    end
    @(negedge clk);
    setIdle();
    #1;
    nTests++;
    if (ctrlState !== 2'd1 || actOut() !== 5'b11101) begin
      nFail++; $display("FAIL simul_refill: state %0d out %b expected 1 11101", ctrlState, actOut());
    end
    @(negedge clk);
    setLoadUse();
    branchTaken = 1'b1;
    #1;
    nTests++;
    if (actOut() !== 5'b11111) begin
      nFail++; $display("FAIL simul_branch_over_loaduse: got %b expected 11111", actOut());
    end
    @(negedge clk);
    setIdle();
    @(negedge clk);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1;
    setIdle();
    @(negedge clk);
    rst = 1'b0;
    setLoadUse();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      nTests++;
      if (stallSat !== 4'((i < 15) ? i : 15)) begin
        nFail++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, stallSat, (i < 15) ? i : 15);
      end
    end
    @(negedge clk);
    setIdle();
    #1;
    nTests++;
    if (stallSat !== 4'hF || stallCycles !== 32'd20) begin
      nFail++; $display("FAIL sat_final: sat %0d wide %0d expected 15 20", stallSat, stallCycles);
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 79) == 0);
      memBusy     = ($urandom_range(0, 5) == 0);
      branchTaken = ($urandom_range(0, 5) == 0);
      exMemRead   = ($urandom_range(0, 1) == 1);
      idUsesRs2   = ($urandom_range(0, 1) == 1);
      exRd        = 5'($urandom_range(0, 3));
      idRs1       = 5'($urandom_range(0, 3));
      idRs2       = 5'($urandom_range(0, 3));
      #1;
      exp_q.push_back(expOut());
      e = exp_q.pop_front();
      nTests++;
      if (actOut() !== e) begin
        nFail++; $display("FAIL rand_out_%0d: got %b expected %b", i, actOut(), e);
      end
      nTests++;
      if (ctrlState !== expState()) begin
        nFail++; $display("FAIL rand_state_%0d: got %0d expected %0d", i, ctrlState, expState());
      end
      nTests++;
      if (stallCycles !== mStalls || stallSat !== 4'(mStallsSat)) begin
        nFail++; $display("FAIL rand_stalls_%0d: got %0d/%0d expected %0d/%0d", i, stallCycles, stallSat, mStalls, mStallsSat);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    setIdle();
  endtask

  initial begin
    setIdle();
    test_reset();
    test_load_use();
    test_branch();
    test_freeze_refill();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
